// File: rtl/exp_pwm_multi.sv
// Multi-channel PWM with exponential level-to-duty mapping and per-channel
// ramp generators (static, triangle, sawtooth). One shared 8-bit counter sets
// the 256-clock period. Duties are latched only at the period boundary, so
// outputs never glitch mid-period.
module exp_pwm_multi #(
  parameter int CHANNELS = 4,
  parameter int CH_BITS  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [CH_BITS-1:0]  cfg_ch,
  input  logic [1:0]          cfg_sel,
  input  logic [7:0]          cfg_data,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_start
);

  localparam logic [1:0] MODE_OFF    = 2'd0;
  localparam logic [1:0] MODE_STATIC = 2'd1;
  localparam logic [1:0] MODE_TRI    = 2'd2;
  localparam logic [1:0] MODE_SAW    = 2'd3;

  localparam logic [1:0] SEL_MODE  = 2'd0;
  localparam logic [1:0] SEL_LEVEL = 2'd1;
  localparam logic [1:0] SEL_RATE  = 2'd2;

  // Exponential map: 1.mmmmm mantissa shifted by a 3-bit exponent, then
  // scaled down by 32. Level 0 is forced to a true zero duty.
  function automatic logic [7:0] level_to_duty(input logic [7:0] lvl);
    logic [12:0] mant;
    logic [12:0] shifted;
    mant    = {7'd0, 1'b1, lvl[4:0]};
    shifted = mant << lvl[7:5];
    if (lvl == 8'd0) begin
      return 8'd0;
    end
    return shifted[12:5];
  endfunction

  // Triangle step: bounce off both rails without ever sitting on them twice.
  function automatic logic [8:0] tri_step(input logic [7:0] lvl, input logic up);
    logic [7:0] nlvl;
    logic       nup;
    nlvl = lvl;
    nup  = up;
    if (up) begin
      if (lvl == 8'hFF) begin
        nlvl = 8'hFE;
        nup  = 1'b0;
      end else begin
        nlvl = lvl + 8'd1;
      end
    end else begin
      if (lvl == 8'h00) begin
        nlvl = 8'h01;
        nup  = 1'b1;
      end else begin
        nlvl = lvl - 8'd1;
      end
    end
    return {nup, nlvl};
  endfunction

  logic [7:0]          cnt_q, cnt_d;
  logic                ps_q, ps_d;
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic                wrap;

  logic [1:0] mode_q  [CHANNELS];
  logic [1:0] mode_d  [CHANNELS];
  logic [7:0] level_q [CHANNELS];
  logic [7:0] level_d [CHANNELS];
  logic [7:0] rate_q  [CHANNELS];
  logic [7:0] rate_d  [CHANNELS];
  logic [7:0] rcnt_q  [CHANNELS];
  logic [7:0] rcnt_d  [CHANNELS];
  logic       up_q    [CHANNELS];
  logic       up_d    [CHANNELS];
  logic [7:0] duty_q  [CHANNELS];
  logic [7:0] duty_d  [CHANNELS];

  // Shared period counter, period marker and registered PWM comparison.
  always_comb begin
    cnt_d = cnt_q + 8'd1;
    wrap  = (cnt_q == 8'hFF);
    ps_d  = (cnt_q == 8'd0);
    pwm_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      pwm_d[i] = (mode_q[i] != MODE_OFF) && (cnt_q < duty_q[i]);
    end
  end

  // Per-channel duty latch, ramp stepping at the period boundary, and config
  // writes; a write overrides whatever the step would have put in that field.
  always_comb begin
    logic [8:0] tri_nxt;
    mode_d  = mode_q;
    level_d = level_q;
    rate_d  = rate_q;
    rcnt_d  = rcnt_q;
    up_d    = up_q;
    duty_d  = duty_q;
    tri_nxt = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (wrap) begin
        duty_d[i] = level_to_duty(level_q[i]);
        if (mode_q[i] != MODE_OFF) begin
          if (rcnt_q[i] == rate_q[i]) begin
            rcnt_d[i] = 8'd0;
            case (mode_q[i])
              MODE_TRI: begin
                tri_nxt    = tri_step(level_q[i], up_q[i]);
                level_d[i] = tri_nxt[7:0];
                up_d[i]    = tri_nxt[8];
              end
              MODE_SAW: level_d[i] = level_q[i] + 8'd1;
              default:  level_d[i] = level_q[i];
            endcase
          end else begin
            rcnt_d[i] = rcnt_q[i] + 8'd1;
          end
        end
      end
      if (cfg_we && (cfg_ch == CH_BITS'(i))) begin
        case (cfg_sel)
          SEL_MODE: begin
            mode_d[i] = cfg_data[1:0];
            up_d[i]   = 1'b1;
          end
          SEL_LEVEL: level_d[i] = cfg_data;
          SEL_RATE: begin
            rate_d[i] = cfg_data;
            rcnt_d[i] = 8'd0;
          end
          default: ;
        endcase
      end
    end
  end

  // State registers; reset returns every channel to OFF with zero duty.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 8'd0;
      ps_q  <= 1'b0;
      pwm_q <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        mode_q[i]  <= MODE_OFF;
        level_q[i] <= 8'd0;
        rate_q[i]  <= 8'd0;
        rcnt_q[i]  <= 8'd0;
        up_q[i]    <= 1'b1;
        duty_q[i]  <= 8'd0;
      end
    end else begin
      cnt_q <= cnt_d;
      ps_q  <= ps_d;
      pwm_q <= pwm_d;
      for (int i = 0; i < CHANNELS; i++) begin
        mode_q[i]  <= mode_d[i];
        level_q[i] <= level_d[i];
        rate_q[i]  <= rate_d[i];
        rcnt_q[i]  <= rcnt_d[i];
        up_q[i]    <= up_d[i];
        duty_q[i]  <= duty_d[i];
      end
    end
  end

  assign pwm_out      = pwm_q;
  assign period_start = ps_q;

endmodule
